// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory controller.
// State encoding, access size codes and alignment helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // size 2'b11 behaves as a word access
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    if (size == SIZE_BYTE) return 1'b0;
    if (size == SIZE_HALF) return off[0];
    return (off != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: big-endian lane steering for stores and loads.
// Byte enables, store replication, load extract/extend.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // offset 0 lives in bits 31:24
  always_comb begin
    byte_v = rdata_i[31:24];
    case (off_i)
      2'd0:    byte_v = rdata_i[31:24];
      2'd1:    byte_v = rdata_i[23:16];
      2'd2:    byte_v = rdata_i[15:8];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = off_i[1] ? rdata_i[15:0]
                      : rdata_i[31:16];
  end

  // select enables, replicated data and extended result
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b1000 >> off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & byte_v[7]}},
                   byte_v};
      end
      SIZE_HALF: begin
        be_o    = off_i[1] ? 4'b0011 : 4'b1100;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_i & half_v[15]}},
                   half_v};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage load/store to req/ack bus bridge.
// Stalls the pipeline until the access completes.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        dmem_wait,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] TMO    = 16'(TIMEOUT);
  localparam logic        TMO_EN = (TIMEOUT != 0);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        sign_q;

  logic        access;
  logic        is_idle;
  logic        mis;
  logic [1:0]  l_size;
  logic [1:0]  l_off;
  logic        l_sign;
  logic [3:0]  l_be;
  logic [31:0] l_wdata;
  logic [31:0] l_rdata;

  assign access  = enable & (mem_read | mem_write);
  assign is_idle = (state_q == ST_IDLE);
  assign mis     = misaligned(mem_size, addr[1:0]);

  assign dmem_wait = (is_idle & access)
                   | (state_q == ST_REQ);

  // live request drives lanes in IDLE, latched one after
  assign l_size = is_idle ? mem_size   : size_q;
  assign l_off  = is_idle ? addr[1:0]  : off_q;
  assign l_sign = is_idle ? mem_signed : sign_q;

  dmem_lane u_lane (
    .size_i  (l_size),
    .sign_i  (l_sign),
    .off_i   (l_off),
    .wdata_i (wdata),
    .rdata_i (bus_rdata),
    .be_o    (l_be),
    .wdata_o (l_wdata),
    .rdata_o (l_rdata)
  );

  // access FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      size_q    <= SIZE_BYTE;
      off_q     <= 2'b00;
      sign_q    <= 1'b0;
      rdata     <= '0;
      bus_error <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access && mis) begin
            bus_error <= 1'b1;
            rdata     <= '0;
            state_q   <= ST_DONE;
          end else if (access) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= l_be;
            bus_wdata <= l_wdata;
            size_q    <= mem_size;
            off_q     <= addr[1:0];
            sign_q    <= mem_signed;
            cnt_q     <= '0;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) rdata <= l_rdata;
            state_q <= ST_DONE;
          end else if (TMO_EN && cnt_q == TMO) begin
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
            rdata     <= '0;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl.
// Hand-computed expectations, TIMEOUT set to 4.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        dmem_wait;
  logic        bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  int          stalls;
  int          reqc;
  logic [3:0]  c_be;
  logic [31:0] c_addr;
  logic [31:0] c_wd;
  logic        c_we;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .dmem_wait  (dmem_wait),
    .bus_error  (bus_error),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // one access; ack after dly REQ cycles
  task automatic run(
    input logic        rd,
    input logic        wr,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] wd,
    input int          dly,
    input logic [31:0] brd
  );
    bit done;
    done = 1'b0;
    @(negedge clk);
    enable     = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    mem_size   = sz;
    mem_signed = sg;
    addr       = a;
    wdata      = wd;
    stalls     = 0;
    reqc       = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!dmem_wait) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (bus_req) begin
        c_be   = bus_be;
        c_addr = bus_addr;
        c_wd   = bus_wdata;
        c_we   = bus_we;
        if (reqc == dly) begin
          bus_ack   = 1'b1;
          bus_rdata = brd;
        end
        reqc++;
      end
      @(negedge clk);
      bus_ack = 1'b0;
    end
    if (!done) chk("wait_bound", 32'd0, 32'd1);
    chk("done_req_low", {31'd0, bus_req}, 32'd0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_size   = 2'b00;
    mem_signed = 1'b0;
    addr       = '0;
    wdata      = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    c_be       = '0;
    c_addr     = '0;
    c_wd       = '0;
    c_we       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, bus_error}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_wd", bus_wdata, 32'd0);
    chk("rst_wait", {31'd0, dmem_wait}, 32'd0);

    rst      = 1'b0;
    mem_read = 1'b1;
    #1;
    chk("en0_wait", {31'd0, dmem_wait}, 32'd0);
    @(negedge clk);
    chk("en0_req", {31'd0, bus_req}, 32'd0);
    mem_read = 1'b0;

    run(1, 0, 2'b10, 0, 32'h100, 0, 0, 32'hDEADBEEF);
    chk("w_stall", stalls, 2);
    chk("w_be", {28'd0, c_be}, 32'hF);
    chk("w_addr", c_addr, 32'h100);
    chk("w_we", {31'd0, c_we}, 32'd0);
    chk("w_rdata", rdata, 32'hDEADBEEF);
    chk("w_err", {31'd0, bus_error}, 32'd0);

    run(1, 0, 2'b00, 1, 32'h103, 0, 0, 32'h000000F0);
    chk("sb_be", {28'd0, c_be}, 32'h1);
    chk("sb_rdata", rdata, 32'hFFFFFFF0);

    run(1, 0, 2'b00, 0, 32'h103, 0, 0, 32'h000000F0);
    chk("ub_rdata", rdata, 32'h000000F0);

    run(1, 1, 2'b01, 0, 32'h202,
        32'h1234ABCD, 0, 32'h55555555);
    chk("hs_addr", c_addr, 32'h200);
    chk("hs_be", {28'd0, c_be}, 32'h3);
    chk("hs_wd", c_wd, 32'hABCDABCD);
    chk("hs_we", {31'd0, c_we}, 32'd1);
    chk("hs_rdata", rdata, 32'h000000F0);

    run(1, 0, 2'b01, 1, 32'h100, 0, 2, 32'h80012345);
    chk("sh_stall", stalls, 4);
    chk("sh_be", {28'd0, c_be}, 32'hC);
    chk("sh_rdata", rdata, 32'hFFFF8001);

    run(0, 1, 2'b00, 0, 32'h101, 32'h000000A5, 0, 0);
    chk("bs_be", {28'd0, c_be}, 32'h4);
    chk("bs_wd", c_wd, 32'hA5A5A5A5);

    run(1, 0, 2'b00, 1, 32'h101, 0, 0, 32'h12803456);
    chk("sb1_rdata", rdata, 32'hFFFFFF80);

    run(1, 0, 2'b11, 0, 32'h104, 0, 0, 32'h11223344);
    chk("s11_be", {28'd0, c_be}, 32'hF);
    chk("s11_rdata", rdata, 32'h11223344);

    run(1, 0, 2'b10, 0, 32'h108, 0, 4, 32'hCAFEF00D);
    chk("race_reqc", reqc, 5);
    chk("race_err", {31'd0, bus_error}, 32'd0);
    chk("race_rdata", rdata, 32'hCAFEF00D);

    run(1, 0, 2'b10, 0, 32'h10C, 0, 100, 32'h0);
    chk("to_reqc", reqc, 5);
    chk("to_stall", stalls, 6);
    chk("to_err", {31'd0, bus_error}, 32'd1);
    chk("to_rdata", rdata, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_err", {31'd0, bus_error}, 32'd0);

    run(1, 0, 2'b10, 0, 32'h100, 0, 0, 32'h77777777);
    chk("pre_rdata", rdata, 32'h77777777);

    run(1, 0, 2'b10, 0, 32'h101, 0, 0, 32'h99999999);
    chk("mis_stall", stalls, 1);
    chk("mis_reqc", reqc, 0);
    chk("mis_rdata", rdata, 32'd0);
    chk("mis_err", {31'd0, bus_error}, 32'd1);

    run(1, 0, 2'b01, 0, 32'h203, 0, 0, 32'h99999999);
    chk("mish_stall", stalls, 1);
    chk("mish_reqc", reqc, 0);

    run(1, 0, 2'b10, 0, 32'h100, 0, 0, 32'hAA55AA55);
    chk("stk_rdata", rdata, 32'hAA55AA55);
    chk("stk_err", {31'd0, bus_error}, 32'd1);

    @(negedge clk);
    enable   = 1'b1;
    mem_read = 1'b1;
    mem_size = 2'b10;
    addr     = 32'h300;
    @(negedge clk);
    chk("rr_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_req0", {31'd0, bus_req}, 32'd0);
    chk("rr_err", {31'd0, bus_error}, 32'd0);
    rst       = 1'b0;
    mem_read  = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late_req", {31'd0, bus_req}, 32'd0);
    chk("late_rdata", rdata, 32'd0);
    chk("late_wait", {31'd0, dmem_wait}, 32'd0);
    @(negedge clk);
    chk("late_rdata2", rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller sitting between the MEM stage of the mMIPS pipeline and the external data-memory bus. It turns single-cycle load/store requests from the pipeline into a req/ack bus transaction, and drives `dmem_wait` to the hazard unit so the pipeline freezes until the access completes. It also performs big-endian byte/half-word lane steering, load sign/zero extension, misalignment detection and bus timeout.

## Interface
- `TIMEOUT`, 255: max cycles in REQ without `bus_ack` before abort; 0 disables timeout.
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  pipeline enable; when 0 no new access is started
- `mem_read`  in  1  MEM-stage load
- `mem_write`  in  1  MEM-stage store; wins if both asserted
- `mem_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `mem_signed`  in  1  sign-extend byte/half loads
- `addr`  in  32  byte address
- `wdata`  in  32  store data, right-aligned
- `rdata`  out  32  load result, valid in DONE
- `dmem_wait`  out  1  stall request to hazard unit
- `bus_error`  out  1  sticky misalign/timeout flag, cleared only by `rst`
- `bus_req`  out  1  bus request, held until ack or timeout
- `bus_we`  out  1  1 = write
- `bus_addr`  out  32  `{addr[31:2],2'b00}`
- `bus_be`  out  4  byte enables, `bus_be[3]` = bits 31:24 = offset 0
- `bus_wdata`  out  32  store data replicated across lanes
- `bus_ack`  in  1  completion, one cycle
- `bus_rdata`  in  32  read data, sampled with `bus_ack`

## Operation
- access = `enable & (mem_read | mem_write)`.
- States: IDLE, REQ, DONE.
- IDLE: if access and aligned -> REQ, latching addr, size, signed, we, wdata. If access and misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE directly, `bus_error`<=1, rdata<=0, no bus cycle.
- REQ: `bus_req`=1, bus outputs from latched values, stable every cycle. On `bus_ack`: capture lane-extracted `bus_rdata` (loads), -> DONE. On timeout counter == TIMEOUT (TIMEOUT!=0) without ack: `bus_error`<=1, rdata<=0, -> DONE.
- DONE: `dmem_wait`=0 for exactly one cycle; pipeline advances; -> IDLE unconditionally.
- `dmem_wait` = (IDLE & access) | REQ. Combinational from inputs in IDLE, so the hazard unit freezes in the same cycle the access appears.
- Lane rules: byte `bus_be` = 4'b1000 >> addr[1:0]; half `bus_be` = addr[1] ? 0011 : 1100; word 1111. Store byte data replicated ×4, half ×2. Load extraction picks the addressed lane, then sign- or zero-extends per `mem_signed`.
- `bus_ack` outside REQ is ignored. Store: rdata unchanged.

## Timing
- Reset values: state IDLE, `rdata`=0, `bus_error`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, timeout counter 0; `dmem_wait` = access (combinational).
- Minimum aligned access: cycle0 IDLE (wait=1), cycle1 REQ with ack (wait=1), cycle2 DONE (wait=0, rdata valid). Two stall cycles. Each extra ack-delay cycle adds one.
- Misaligned access: one stall cycle.
- Back-to-back: the new access may appear the cycle after DONE. IDLE re-asserts wait immediately.
- `rst` in REQ: next edge forces IDLE and drops `bus_req`; a late `bus_ack` is ignored.
- Ack and timeout in the same cycle: ack wins, no error.

## Structure
- Shared package `dmem_pkg`: state encoding, `SIZE_BYTE/HALF/WORD` constants.
- Sub-module `dmem_lane` (combinational): be/wdata generation and load extraction/extension. Reused for store and load paths.

## Test plan
- Word load addr 0x100, ack one cycle after req, `bus_rdata`=0xDEADBEEF -> wait high 2 cycles, rdata=0xDEADBEEF in DONE, bus_be=1111.
- Signed byte load addr 0x103, `bus_rdata`=0x000000F0 -> bus_be=0001, rdata=0xFFFFFFF0. Unsigned -> 0x000000F0.
- Half store addr 0x202, wdata=0x1234ABCD -> bus_addr=0x200, bus_be=0011, bus_wdata=0xABCDABCD, bus_we=1.
- Word load addr 0x101 -> no `bus_req`, one stall cycle, rdata=0, bus_error=1 and stays set.
- TIMEOUT=4, no ack -> bus_req for 5 cycles, then DONE with bus_error=1. Reset during REQ -> IDLE next edge, later ack ignored.
